sim_result_monitor: RTL and testbench
=====================================

Name: sim_result_monitor

Overview:
- Reusable bus-snooping result checker for CPU program tests; sits beside cpu_top on the data-memory write port (d_mem_addr/d_mem_wdata/d_mem_wen).
- Captures NUM_ELEM result words written to a programmable window and waits for a completion-flag write or a cycle timeout.
- Then checks every element against an expected table plus a configurable ordering rule, and reports pass/fail.
- Generalises the fixed 10-element ascending check in the current benches to any depth, width, base address, flag and ordering mode, with byte-lane merging.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32 (4 byte lanes)
- NUM_ELEM, 10, result elements captured and checked (1..256)
- IDX_W, 8, index width; must satisfy 2^IDX_W >= NUM_ELEM
- RESULT_BASE, 32'h300, byte address of element 0; word-aligned
- FLAG_ADDR, 32'h400, completion-flag byte address; word-aligned; outside the result window
- FLAG_VALUE, 1, data value that signals completion
- MAX_CYCLES, 5000, ARMED cycles before timeout (>=1)
- CNT_W, 16, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES
- ORDER_MODE, 0, ordering rule: 0 = non-decreasing, 1 = non-increasing, 2 = no order check

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: clear capture buffer and arm
- d_mem_addr  in  ADDR_W  snooped write address
- d_mem_wdata  in  DATA_W  snooped write data
- d_mem_wen  in  4  snooped byte-lane write enables
- exp_wr_en  in  1  load one expected value
- exp_wr_idx  in  IDX_W  expected-table index
- exp_wr_data  in  DATA_W  expected value
- rd_idx  in  IDX_W  capture-buffer readback index
- rd_data  out  DATA_W  captured[rd_idx], combinational; 0 when rd_idx >= NUM_ELEM
- state  out  2  0 IDLE, 1 ARMED, 2 CHECK, 3 DONE
- done  out  1  check complete, results valid
- pass  out  1  all elements match, order ok, no timeout
- timeout  out  1  ARMED ended by cycle limit
- order_ok  out  1  ordering rule satisfied
- match_count  out  IDX_W+1  elements equal to expected
- cycle_count  out  CNT_W  ARMED cycles elapsed

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - done, pass, timeout, match_count, cycle_count = 0; order_ok=1.
  - Capture buffer and expected table cleared to 0.
- IDLE/DONE:
  - exp_wr_en with exp_wr_idx < NUM_ELEM writes the expected table. Out-of-range index is ignored.
  - In ARMED or CHECK, exp_wr_en is ignored.
- start in IDLE, DONE or ARMED:
  - Next state ARMED.
  - Capture buffer zeroed; cycle_count, match_count, done, pass, timeout cleared; order_ok=1.
  - Snooped writes on the same edge as start are discarded.
  - start in CHECK is ignored.
- ARMED:
  - cycle_count increments each edge.
  - Capture: a write with d_mem_wen != 0, d_mem_addr[1:0]==0 and RESULT_BASE <= addr < RESULT_BASE+4*NUM_ELEM updates element (addr-RESULT_BASE)>>2, merging only the enabled byte lanes. Last write wins.
  - Misaligned addresses are ignored.
- Flag accept: addr==FLAG_ADDR, d_mem_wen==4'b1111 and d_mem_wdata==FLAG_VALUE → CHECK.
  - A flag write with any other value, or a partial flag write, is ignored.
- Timeout: no flag accept on the edge where cycle_count==MAX_CYCLES-1 → CHECK, timeout=1, cycle_count=MAX_CYCLES.
  - Flag accept on that same edge wins: timeout stays 0.
- CHECK:
  - One element per edge, index 0..NUM_ELEM-1.
  - match_count increments on equality.
  - For i>0 the order rule compares captured[i-1] to captured[i] (unsigned); a violation clears order_ok.
  - Snooped writes are ignored.
- DONE:
  - Entered NUM_ELEM edges after the flag-accept or timeout edge; done=1 from that edge.
  - pass = (match_count==NUM_ELEM) && order_ok && !timeout.
  - Outputs hold until start or reset.

Optional Feature:
- RESULT_MON_SIGNED_CMP_EN:
  - Defined: order comparisons treat captured words as two's-complement signed.
  - Undefined: order comparisons are unsigned.
  - Equality checks are unaffected in both cases.

Test Plan:
- Load expected 1..10; start; word writes 9,3,7,1,5,8,2,6,4,10 then 1,2,…,10 to 0x300..0x324; write 1 to 0x400 → done 10 edges later, match_count=10, order_ok=1, pass=1.
- Element 0x30C left at 0; flag → match_count=9, order_ok=0 (0 after 3), pass=0.
- MAX_CYCLES=8, no flag → timeout=1 after 8 ARMED edges, cycle_count=8, pass=0 even if data match. Flag on edge 8 instead → timeout=0.
- Byte writes wen=0001 data 0x..AA then wen=0100 data 0x..BB..00 to 0x300 → rd_data(idx0)=0x00BB00AA. Misaligned 0x301 write ignored.
- Write 2 to 0x400 → stays ARMED. Then write 1 → CHECK. Assert rst_n=0 mid-CHECK → state=IDLE, all outputs at reset values immediately.
- Build with RESULT_MON_SIGNED_CMP_EN, ORDER_MODE=0: capture -1,0,1,… → order_ok=1. Without the macro → order_ok=0.

Source files
------------

// File: rtl/sim_result_monitor.sv
// Bus-snooping result checker: captures NUM_ELEM words from a write window, waits for a flag or timeout, then checks them.
// Optional macro RESULT_MON_SIGNED_CMP_EN makes the ordering comparisons two's-complement signed.
module sim_result_monitor #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_ELEM    = 10,
    parameter int                IDX_W       = 8,
    parameter logic [ADDR_W-1:0] RESULT_BASE = 'h300,
    parameter logic [ADDR_W-1:0] FLAG_ADDR   = 'h400,
    parameter logic [DATA_W-1:0] FLAG_VALUE  = 'h1,
    parameter int                MAX_CYCLES  = 5000,
    parameter int                CNT_W       = 16,
    parameter int                ORDER_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    input  logic [3:0]        d_mem_wen,
    input  logic              exp_wr_en,
    input  logic [IDX_W-1:0]  exp_wr_idx,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        state,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              order_ok,
    output logic [IDX_W:0]    match_count,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] WIN_END  = RESULT_BASE + ADDR_W'(4 * NUM_ELEM);
    localparam logic [IDX_W:0]    NUM_MC   = (IDX_W+1)'(NUM_ELEM);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ELEM - 1);
    localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    state_t            st;
    logic [DATA_W-1:0] cap     [NUM_ELEM];
    logic [DATA_W-1:0] exp_tab [NUM_ELEM];
    logic [IDX_W-1:0]  chk_idx;

    logic [ADDR_W-1:0] win_off;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_hit;
    logic              flag_hit;
    logic              exp_load;
    logic [IDX_W-1:0]  prv_idx;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] prv_word;
    logic              prv_gt;
    logic              prv_lt;
    logic              order_viol;
    logic              elem_eq;
    logic [IDX_W:0]    mc_next;
    logic              ok_next;

    assign state   = st;
    assign rd_data = ({1'b0, rd_idx} < NUM_MC) ? cap[rd_idx] : '0;

    always_comb begin
        win_off  = d_mem_addr - RESULT_BASE;
        cap_idx  = IDX_W'(win_off >> 2);
        cap_hit  = (d_mem_wen != 4'b0000) && (d_mem_addr[1:0] == 2'b00) &&
                   (d_mem_addr >= RESULT_BASE) && (d_mem_addr < WIN_END);
        flag_hit = (d_mem_addr == FLAG_ADDR) && (d_mem_wen == 4'b1111) &&
                   (d_mem_wdata == FLAG_VALUE);
        exp_load = exp_wr_en && ({1'b0, exp_wr_idx} < NUM_MC) &&
                   ((st == S_IDLE) || (st == S_DONE));
    end

    // Element chk_idx is compared against its predecessor; element 0 has none.
    always_comb begin
        prv_idx  = (chk_idx == '0) ? '0 : chk_idx - IDX_W'(1);
        cur_word = cap[chk_idx];
        prv_word = cap[prv_idx];
`ifdef RESULT_MON_SIGNED_CMP_EN
        prv_gt   = $signed(prv_word) > $signed(cur_word);
        prv_lt   = $signed(prv_word) < $signed(cur_word);
`else
        prv_gt   = prv_word > cur_word;
        prv_lt   = prv_word < cur_word;
`endif
        case (ORDER_MODE)
            0:       order_viol = prv_gt;
            1:       order_viol = prv_lt;
            default: order_viol = 1'b0;
        endcase
        if (chk_idx == '0) begin
            order_viol = 1'b0;
        end
        elem_eq = (cur_word == exp_tab[chk_idx]);
        mc_next = match_count + (IDX_W+1)'(elem_eq);
        ok_next = order_ok && !order_viol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            order_ok    <= 1'b1;
            match_count <= '0;
            cycle_count <= '0;
            chk_idx     <= '0;
            for (int unsigned i = 0; i < NUM_ELEM; i++) begin
                cap[i]     <= '0;
                exp_tab[i] <= '0;
            end
        end else begin
            if (exp_load) begin
                exp_tab[exp_wr_idx] <= exp_wr_data;
            end
            // A start outside CHECK re-arms and discards any write on the same edge.
            if (start && (st != S_CHECK)) begin
                st          <= S_ARMED;
                done        <= 1'b0;
                pass        <= 1'b0;
                timeout     <= 1'b0;
                order_ok    <= 1'b1;
                match_count <= '0;
                cycle_count <= '0;
                chk_idx     <= '0;
                for (int unsigned i = 0; i < NUM_ELEM; i++) begin
                    cap[i] <= '0;
                end
            end else begin
                case (st)
                    S_ARMED: begin
                        cycle_count <= cycle_count + CNT_W'(1);
                        if (cap_hit) begin
                            for (int unsigned b = 0; b < 4; b++) begin
                                if (d_mem_wen[b]) begin
                                    cap[cap_idx][8*b +: 8] <= d_mem_wdata[8*b +: 8];
                                end
                            end
                        end
                        if (flag_hit) begin
                            st      <= S_CHECK;
                            chk_idx <= '0;
                        end else if (cycle_count == LAST_CYC) begin
                            st      <= S_CHECK;
                            chk_idx <= '0;
                            timeout <= 1'b1;
                        end
                    end
                    S_CHECK: begin
                        match_count <= mc_next;
                        order_ok    <= ok_next;
                        chk_idx     <= chk_idx + IDX_W'(1);
                        if (chk_idx == LAST_IDX) begin
                            st   <= S_DONE;
                            done <= 1'b1;
                            pass <= (mc_next == NUM_MC) && ok_next && !timeout;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sim_result_monitor.sv
// Randomized self-checking bench for sim_result_monitor against an array-based reference model.
module tb_sim_result_monitor;

    localparam int          N    = 10;
    localparam int          MAXC = 40;
    localparam logic [31:0] BASE = 32'h300;
    localparam logic [31:0] FLAG = 32'h400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic        exp_wr_en;
    logic [7:0]  exp_wr_idx;
    logic [31:0] exp_wr_data;
    logic [7:0]  rd_idx;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        order_ok;
    logic [8:0]  match_count;
    logic [15:0] cycle_count;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_cap [N];
    logic [31:0] m_exp [N];
    int          m_cyc;

    sim_result_monitor #(
        .ADDR_W(32), .DATA_W(32), .NUM_ELEM(N), .IDX_W(8),
        .RESULT_BASE(BASE), .FLAG_ADDR(FLAG), .FLAG_VALUE(32'h1),
        .MAX_CYCLES(MAXC), .CNT_W(16), .ORDER_MODE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata), .d_mem_wen(d_mem_wen),
        .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx), .exp_wr_data(exp_wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .state(state), .done(done), .pass(pass),
        .timeout(timeout), .order_ok(order_ok), .match_count(match_count),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        int k;
        if (w != 4'b0 && a[1:0] == 2'b00 && a >= BASE && a < BASE + 4 * N) begin
            k = int'((a - BASE) / 4);
            for (int b = 0; b < 4; b++)
                if (w[b]) m_cap[k][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic int m_matches();
        int c = 0;
        for (int i = 0; i < N; i++)
            if (m_cap[i] == m_exp[i]) c++;
        return c;
    endfunction

    function automatic logic m_order();
        for (int i = 1; i < N; i++) begin
`ifdef RESULT_MON_SIGNED_CMP_EN
            if ($signed(m_cap[i-1]) > $signed(m_cap[i])) return 1'b0;
`else
            if (m_cap[i-1] > m_cap[i]) return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    function automatic void m_clear_cap();
        for (int i = 0; i < N; i++) m_cap[i] = '0;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; d_mem_addr = '0; d_mem_wdata = '0; d_mem_wen = '0;
        exp_wr_en = 0; exp_wr_idx = '0; exp_wr_data = '0; rd_idx = '0;
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
        m_clear_cap();
        m_cyc = 0;
    endtask

    task automatic load_exp(input int idx, input logic [31:0] d);
        exp_wr_en = 1; exp_wr_idx = 8'(idx); exp_wr_data = d;
        tick();
        exp_wr_en = 0;
        if (idx < N) m_exp[idx] = d;
    endtask

    task automatic snoop(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        d_mem_addr = a; d_mem_wdata = d; d_mem_wen = w;
        tick();
        d_mem_wen = '0;
        m_write(a, d, w);
        m_cyc++;
    endtask

    task automatic send_flag();
        d_mem_addr = FLAG; d_mem_wdata = 32'h1; d_mem_wen = 4'hF;
        tick();
        d_mem_wen = '0;
        m_cyc++;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < N + 5) begin
            tick();
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL reset_pass got %b want 0", pass); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", timeout); end
        tests++; if (order_ok !== 1'b1) begin fails++; $display("FAIL reset_order_ok got %b want 1", order_ok); end
        tests++; if (match_count !== 9'd0) begin fails++; $display("FAIL reset_match got %0d want 0", match_count); end
        tests++; if (cycle_count !== 16'd0) begin fails++; $display("FAIL reset_cycles got %0d want 0", cycle_count); end
        for (int i = 0; i < N; i++) begin
            rd_idx = 8'(i); #1;
            tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd[%0d] got %h want 0", i, rd_data); end
        end
    endtask

    task automatic test_sorted();
        int lat;
        for (int i = 0; i < N; i++) load_exp(i, 32'(i + 1));
        load_exp(N, 32'hDEAD);          // out-of-range index ignored
        do_start();
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL sorted_armed got %0d want 1", state); end
        begin
            int shuf [N] = '{9, 3, 7, 1, 5, 8, 2, 6, 4, 10};
            for (int i = 0; i < N; i++) snoop(BASE + 32'(4 * i), 32'(shuf[i]), 4'hF);
        end
        for (int i = 0; i < N; i++) snoop(BASE + 32'(4 * i), 32'(i + 1), 4'hF);
        send_flag();
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL sorted_check got %0d want 2", state); end
        wait_done(lat);
        tests++; if (lat !== N) begin fails++; $display("FAIL sorted_latency got %0d want %0d", lat, N); end
        tests++; if (match_count !== 9'(m_matches())) begin fails++; $display("FAIL sorted_match got %0d want %0d", match_count, m_matches()); end
        tests++; if (order_ok !== m_order()) begin fails++; $display("FAIL sorted_order got %b want %b", order_ok, m_order()); end
        tests++; if (pass !== 1'b1) begin fails++; $display("FAIL sorted_pass got %b want 1", pass); end
        tests++; if (cycle_count !== 16'(m_cyc)) begin fails++; $display("FAIL sorted_cycles got %0d want %0d", cycle_count, m_cyc); end
        tests++; if (state !== 2'd3) begin fails++; $display("FAIL sorted_done_state got %0d want 3", state); end
    endtask

    task automatic test_hole();
        int lat;
        do_start();
        for (int i = 0; i < N; i++)
            if (i != 3) snoop(BASE + 32'(4 * i), 32'(i + 1), 4'hF);
        send_flag();
        wait_done(lat);
        tests++; if (match_count !== 9'd9 || m_matches() != 9) begin fails++; $display("FAIL hole_match got %0d want 9", match_count); end
        tests++; if (order_ok !== 1'b0) begin fails++; $display("FAIL hole_order got %b want 0", order_ok); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL hole_pass got %b want 0", pass); end
    endtask

    task automatic test_random();
        logic [31:0] v [N];
        logic [31:0] a;
        int lat, k, ops;
        logic exp_pass;
        for (int it = 0; it < 6; it++) begin
            v[0] = 32'($urandom_range(0, 1000));
            for (int i = 1; i < N; i++)
                v[i] = (it % 2 == 0) ? v[i-1] + 32'($urandom_range(0, 3)) : $urandom;
            for (int i = 0; i < N; i++)
                load_exp(i, (it % 3 == 2 && i == 4) ? v[i] ^ 32'h10 : v[i]);
            do_start();
            for (int i = 0; i < N; i++) snoop(BASE + 32'(4 * i), v[i], 4'hF);
            ops = $urandom_range(4, 14);
            for (int o = 0; o < ops; o++) begin
                k = $urandom_range(0, N - 1);
                case ($urandom_range(0, 5))
                    0: snoop(BASE + 32'(4 * k), v[k], 4'hF);
                    1: snoop(BASE + 32'(4 * k), $urandom, 4'($urandom_range(1, 15)));
                    2: snoop(BASE + 32'(4 * k) + 32'($urandom_range(1, 3)), $urandom, 4'hF);
                    3: begin
                        a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'(4 * N);
                        snoop(a, $urandom, 4'hF);
                    end
                    4: begin
                        if ($urandom_range(0, 1) == 0) snoop(FLAG, 32'($urandom_range(2, 100)), 4'hF);
                        else snoop(FLAG, 32'h1, 4'($urandom_range(1, 14)));
                    end
                    default: begin
                        // expected-table writes while ARMED must be dropped
                        exp_wr_en = 1; exp_wr_idx = 8'(k); exp_wr_data = $urandom;
                        tick();
                        exp_wr_en = 0;
                        m_cyc++;
                    end
                endcase
            end
            tests++; if (state !== 2'd1) begin fails++; $display("FAIL rand%0d_armed got %0d want 1", it, state); end
            send_flag();
            wait_done(lat);
            exp_pass = (m_matches() == N) && m_order();
            tests++; if (lat !== N) begin fails++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, N); end
            tests++; if (match_count !== 9'(m_matches())) begin fails++; $display("FAIL rand%0d_match got %0d want %0d", it, match_count, m_matches()); end
            tests++; if (order_ok !== m_order()) begin fails++; $display("FAIL rand%0d_order got %b want %b", it, order_ok, m_order()); end
            tests++; if (pass !== exp_pass) begin fails++; $display("FAIL rand%0d_pass got %b want %b", it, pass, exp_pass); end
            tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rand%0d_timeout got %b want 0", it, timeout); end
            tests++; if (cycle_count !== 16'(m_cyc)) begin fails++; $display("FAIL rand%0d_cycles got %0d want %0d", it, cycle_count, m_cyc); end
            for (int i = 0; i < N; i++) begin
                rd_idx = 8'(i); #1;
                tests++; if (rd_data !== m_cap[i]) begin fails++; $display("FAIL rand%0d_rd[%0d] got %h want %h", it, i, rd_data, m_cap[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        int lat;
        for (int i = 0; i < N; i++) load_exp(i, 32'(i + 1));
        do_start();
        for (int i = 0; i < N; i++) snoop(BASE + 32'(4 * i), 32'(i + 1), 4'hF);
        while (m_cyc < MAXC - 1) begin tick(); m_cyc++; end
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL to_before_limit got %0d want 1", state); end
        tick(); m_cyc++;
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL to_state got %0d want 2", state); end
        tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL to_flag got %b want 1", timeout); end
        tests++; if (cycle_count !== 16'(MAXC)) begin fails++; $display("FAIL to_cycles got %0d want %0d", cycle_count, MAXC); end
        wait_done(lat);
        tests++; if (lat !== N) begin fails++; $display("FAIL to_latency got %0d want %0d", lat, N); end
        tests++; if (match_count !== 9'(m_matches())) begin fails++; $display("FAIL to_match got %0d want %0d", match_count, m_matches()); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL to_pass got %b want 0", pass); end
        // flag landing on the limit edge beats the timeout
        do_start();
        for (int i = 0; i < N; i++) snoop(BASE + 32'(4 * i), 32'(i + 1), 4'hF);
        while (m_cyc < MAXC - 1) begin tick(); m_cyc++; end
        send_flag();
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL flagedge_state got %0d want 2", state); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL flagedge_timeout got %b want 0", timeout); end
        tests++; if (cycle_count !== 16'(MAXC)) begin fails++; $display("FAIL flagedge_cycles got %0d want %0d", cycle_count, MAXC); end
        wait_done(lat);
        tests++; if (pass !== 1'b1) begin fails++; $display("FAIL flagedge_pass got %b want 1", pass); end
    endtask

    task automatic test_bytes();
        do_start();
        snoop(BASE, 32'h123456AA, 4'b0001);
        snoop(BASE, 32'h77BB6600, 4'b0100);
        snoop(BASE + 32'd1, 32'hFFFFFFFF, 4'hF);
        snoop(BASE + 32'(4 * (N - 1)), 32'hCAFE0000, 4'b1100);
        snoop(BASE + 32'(4 * N), 32'h5555_5555, 4'hF);
        rd_idx = 8'd0; #1;
        tests++; if (rd_data !== 32'h00BB00AA || m_cap[0] !== 32'h00BB00AA) begin fails++; $display("FAIL bytes_merge got %h want 00bb00aa", rd_data); end
        rd_idx = 8'(N - 1); #1;
        tests++; if (rd_data !== m_cap[N-1]) begin fails++; $display("FAIL bytes_last got %h want %h", rd_data, m_cap[N-1]); end
        rd_idx = 8'(N); #1;
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rd_oob got %h want 0", rd_data); end
        rd_idx = 8'hFF; #1;
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rd_oob_max got %h want 0", rd_data); end
    endtask

    task automatic test_flag_reset();
        snoop(FLAG, 32'h2, 4'hF);
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL wrongflag_state got %0d want 1", state); end
        snoop(FLAG, 32'h1, 4'b0111);
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL partflag_state got %0d want 1", state); end
        send_flag();
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL goodflag_state got %0d want 2", state); end
        tick();
        rst_n = 0;
        #1;
        m_clear_cap();
        for (int i = 0; i < N; i++) m_exp[i] = '0;
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL midreset_state got %0d want 0", state); end
        tests++; if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL midreset_flags got %b%b%b want 000", done, pass, timeout); end
        tests++; if (order_ok !== 1'b1) begin fails++; $display("FAIL midreset_order got %b want 1", order_ok); end
        tests++; if (match_count !== 9'd0 || cycle_count !== 16'd0) begin fails++; $display("FAIL midreset_counts got %0d/%0d want 0/0", match_count, cycle_count); end
        rd_idx = 8'd0; #1;
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL midreset_rd got %h want 0", rd_data); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int i = 0; i < N; i++) load_exp(i, 32'(i + 1));
        do_start();
        for (int i = 0; i < 5; i++) snoop(BASE + 32'(4 * i), 32'hF0 + 32'(i), 4'hF);
        // restart while ARMED with a write on the same edge
        d_mem_addr = BASE; d_mem_wdata = 32'h55; d_mem_wen = 4'hF; start = 1;
        tick();
        start = 0; d_mem_wen = '0;
        m_clear_cap(); m_cyc = 0;
        rd_idx = 8'd0; #1;
        tests++; if (rd_data !== m_cap[0]) begin fails++; $display("FAIL restart_rd got %h want %h", rd_data, m_cap[0]); end
        tests++; if (cycle_count !== 16'd0 || state !== 2'd1) begin fails++; $display("FAIL restart_state got %0d/%0d want 0/1", cycle_count, state); end
        for (int i = 0; i < N; i++) snoop(BASE + 32'(4 * i), 32'(i + 1), 4'hF);
        send_flag();
        // start, expected-table and snoop writes during CHECK are all dropped
        start = 1; exp_wr_en = 1; exp_wr_idx = 8'd0; exp_wr_data = 32'd99;
        d_mem_addr = BASE; d_mem_wdata = 32'h77; d_mem_wen = 4'hF;
        tick();
        start = 0; exp_wr_en = 0; d_mem_wen = '0;
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL check_start_ignored got %0d want 2", state); end
        wait_done(lat);
        tests++; if (lat !== N - 1) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, N - 1); end
        tests++; if (match_count !== 9'(m_matches())) begin fails++; $display("FAIL b2b_match got %0d want %0d", match_count, m_matches()); end
        tests++; if (pass !== 1'b1) begin fails++; $display("FAIL b2b_pass got %b want 1", pass); end
        rd_idx = 8'd0; #1;
        tests++; if (rd_data !== m_cap[0]) begin fails++; $display("FAIL b2b_rd got %h want %h", rd_data, m_cap[0]); end
    endtask

    task automatic test_signed();
        int lat;
        logic want;
`ifdef RESULT_MON_SIGNED_CMP_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        do_start();
        for (int i = 0; i < N; i++) snoop(BASE + 32'(4 * i), 32'(i - 1), 4'hF);
        send_flag();
        wait_done(lat);
        tests++; if (order_ok !== m_order() || order_ok !== want) begin fails++; $display("FAIL signed_order got %b want %b", order_ok, want); end
        tests++; if (match_count !== 9'(m_matches())) begin fails++; $display("FAIL signed_match got %0d want %0d", match_count, m_matches()); end
    endtask

    initial begin
        idle_inputs();
        m_clear_cap();
        for (int i = 0; i < N; i++) m_exp[i] = '0;
        m_cyc = 0;
        rst_n = 0;
        #12;
        test_reset();
        rst_n = 1;
        tick();
        test_sorted();
        test_hole();
        test_random();
        test_timeout();
        test_bytes();
        test_flag_reset();
        test_back_to_back();
        test_signed();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
